// File: rtl/jtframe_romarb_pkg.sv
// Shared definitions for the ROM arbiter.
//   state_t : arbiter FSM encoding (IDLE / WAIT_ACK / WAIT_RDY)
//   clog2   : width of a grant index for n requesters (never below 1 bit)
package jtframe_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One-entry ROM cache for a single requester.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : clears the valid bit on this edge and masks the hit right away
//   cs, addr    : requester chip select and address, compared against the tag
//   fill        : write tag/data from the SDRAM side on this edge
//   fill_keep   : valid value written by a fill (0 when the fill must be discarded)
//   fill_addr   : tag to store (the latched SDRAM address)
//   fill_data   : data to store
//   hit         : cs & valid & tag match & ~flush (combinational from registers)
//   data        : stored data, always visible
module jtframe_romarb_slot #(
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic          fill_keep,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic          valid;
    logic [AW-1:0] tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill) begin
                tag  <= fill_addr;
                data <= fill_data;
            end
            // A flush on the same edge as a fill always wins.
            if (flush)     valid <= 1'b0;
            else if (fill) valid <= fill_keep;
        end
    end

    assign hit = cs & valid & (tag == addr) & ~flush;

endmodule

// File: rtl/jtframe_romarb.sv
// Shares one SDRAM ROM read port between N requesters, each with a one-entry cache.
// Build option: define JTFRAME_ROMARB_FIXPRIO_EN for fixed priority (lowest index
// wins, pointer held at 0); otherwise misses are granted round-robin.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : invalidate every cache entry
//   req_cs   [N]          : per-requester chip select
//   req_addr [N*AW]       : requester i at [i*AW+:AW]
//   req_ok   [N]          : combinational hit, feeds the CPU wait-state generator
//   req_data [N*DW]       : requester i at [i*DW+:DW]
//   sdram_req, sdram_addr : registered read request toward the SDRAM
//   sdram_ack, sdram_rdy  : SDRAM accept pulse and data-valid pulse
//   sdram_data            : read data, valid with sdram_rdy
//   st_dbg                : current FSM state (state_t encoding)
//
// SDRAM handshake: sdram_req rises with sdram_addr and both hold steady until the
// cycle sdram_ack is seen; req drops on that edge. Exactly one sdram_rdy pulse then
// returns the data, possibly in the very cycle of sdram_ack. There is no timeout.
module jtframe_romarb
    import jtframe_romarb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [N-1:0]    req_cs,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    req_ok,
    output logic [N*DW-1:0] req_data,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [DW-1:0]   sdram_data,
    output logic [1:0]      st_dbg
);

    localparam int GW = clog2(N);

    state_t        state, state_nx;
    logic [GW-1:0] grant, grant_nx;
    logic [GW-1:0] ptr, ptr_nx;
    logic [GW-1:0] pick, idx;
    logic          found;
    logic          dirty, dirty_nx;
    logic          req_nx;
    logic [AW-1:0] addr_nx;
    logic          fill;
    logic [N-1:0]  hit, miss, fill_sel;
    logic [AW-1:0] addr_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign fill_sel[i] = fill && (grant == GW'(i));

        jtframe_romarb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .cs        (req_cs[i]),
            .addr      (addr_arr[i]),
            .fill      (fill_sel[i]),
            .fill_keep (~(dirty | flush)),
            .fill_addr (sdram_addr),
            .fill_data (sdram_data),
            .hit       (hit[i]),
            .data      (req_data[i*DW +: DW])
        );
    end

    assign req_ok = hit;
    assign miss   = req_cs & ~hit;
    assign st_dbg = state;

    // First missing requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(ptr) + k) % N);
            if (!found && miss[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = sdram_req;
        addr_nx  = sdram_addr;
        grant_nx = grant;
        ptr_nx   = ptr;
        // Any flush between grant and fill poisons the fill.
        dirty_nx = dirty | flush;
        fill     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nx = ST_WAIT_ACK;
                    req_nx   = 1'b1;
                    addr_nx  = addr_arr[pick];
                    grant_nx = pick;
                    dirty_nx = flush;
`ifdef JTFRAME_ROMARB_FIXPRIO_EN
                    ptr_nx   = '0;
`else
                    ptr_nx   = (int'(pick) == N-1) ? '0 : pick + 1'b1;
`endif
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nx = 1'b0;
                    if (sdram_rdy) begin
                        fill     = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_WAIT_RDY;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (sdram_rdy) begin
                    fill     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            grant      <= '0;
            ptr        <= '0;
            dirty      <= 1'b0;
        end else begin
            state      <= state_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
            grant      <= grant_nx;
            ptr        <= ptr_nx;
            dirty      <= dirty_nx;
        end
    end

endmodule
